// File: rtl/serial_add_pkg.sv
// Purpose : shared constants for the bit-serial adder controller.
// Latency : n/a (definitions only).
// Backpressure: n/a.
// Contents: FSM state width and state codes (IDLE/RUN/DONE; code 3 unused).
package serial_add_pkg;

   localparam int ST_W = 2;

   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
   localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_add_fa.sv
// Purpose : one-bit full adder cell (module fa), purely combinational.
// Latency : 0 cycles.
// Backpressure: none.
// Ports   : a, b, c - addend bits and carry-in; co - carry-out; sum - sum bit.
module fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic co,
   output logic sum
);

   assign sum = a ^ b ^ c;
   assign co  = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial adder; sequences one fa cell LSB first over WIDTH bits.
// Latency : result valid WIDTH cycles after operand accept; WIDTH+2 cycle period.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
// Ports   : clk, rst_n (async active-low); in_valid/in_ready with a_in, b_in, cin;
//           out_valid/out_ready with sum_out, cout; busy high in RUN or DONE.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             busy
);

   // Counter needs at least one bit even for the smallest legal WIDTH.
   localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [ST_W-1:0]  r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic             r_c_q;
   logic [CW-1:0]    r_cnt;

   logic w_sum;
   logic w_co;

   fa u_fa (
      .a   (r_a_sh[0]),
      .b   (r_b_sh[0]),
      .c   (r_c_q),
      .co  (w_co),
      .sum (w_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_c_q    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a_sh  <= a_in;
                  r_b_sh  <= b_in;
                  r_c_q   <= cin;
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at [0].
               r_res_sh <= {w_sum, r_res_sh[WIDTH-1:1]};
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_c_q    <= w_co;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Handshake outputs come from registered state only.
   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);

   // After the last RUN edge the carry flop holds the carry out of bit WIDTH-1.
   assign sum_out   = r_res_sh;
   assign cout      = r_c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Index 0 drives the WIDTH=8 instance, index 1 the WIDTH=2 instance.
   int WD[2] = '{8, 2};

   logic        in_valid[2];
   logic        out_ready[2];
   logic        cin[2];
   logic [31:0] a_in[2];
   logic [31:0] b_in[2];

   logic       w8_ir, w8_ov, w8_co, w8_bz;
   logic [7:0] w8_sum;
   logic       w2_ir, w2_ov, w2_co, w2_bz;
   logic [1:0] w2_sum;

   logic        d_ir[2], d_ov[2], d_co[2], d_bz[2];
   logic [31:0] d_sum[2];
   assign d_ir[0]  = w8_ir;   assign d_ir[1]  = w2_ir;
   assign d_ov[0]  = w8_ov;   assign d_ov[1]  = w2_ov;
   assign d_co[0]  = w8_co;   assign d_co[1]  = w2_co;
   assign d_bz[0]  = w8_bz;   assign d_bz[1]  = w2_bz;
   assign d_sum[0] = {24'd0, w8_sum};
   assign d_sum[1] = {30'd0, w2_sum};

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(w8_ir),
      .a_in(a_in[0][7:0]), .b_in(b_in[0][7:0]), .cin(cin[0]),
      .out_valid(w8_ov), .out_ready(out_ready[0]),
      .sum_out(w8_sum), .cout(w8_co), .busy(w8_bz)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(w2_ir),
      .a_in(a_in[1][1:0]), .b_in(b_in[1][1:0]), .cin(cin[1]),
      .out_valid(w2_ov), .out_ready(out_ready[1]),
      .sum_out(w2_sum), .cout(w2_co), .busy(w2_bz)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [32:0] msk(int i);
      return (33'd1 << WD[i]) - 33'd1;
   endfunction

   task automatic chk(string nm, int i, logic [32:0] act, logic [32:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, i, act, exp, $time);
      end
   endtask

   // Reference model: a transaction is pending from accept until the result is
   // consumed; the result is visible once WIDTH edges have passed since accept.
   bit          m_busy[2] = '{1'b0, 1'b0};
   int          m_cnt[2]  = '{0, 0};
   logic [32:0] m_exp[2]  = '{33'd0, 33'd0};
   logic [32:0] m_last[2] = '{33'd0, 33'd0};

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
            m_exp[i]  = '0;
            m_last[i] = '0;
         end else if (!m_busy[i]) begin
            if (in_valid[i]) begin
               m_busy[i] = 1'b1;
               m_cnt[i]  = 0;
               m_exp[i]  = ({1'b0, a_in[i]} & msk(i)) + ({1'b0, b_in[i]} & msk(i))
                           + 33'(cin[i]);
            end
         end else if (m_cnt[i] < WD[i]) begin
            m_cnt[i]++;
         end else if (out_ready[i]) begin
            m_busy[i] = 1'b0;
            m_last[i] = m_exp[i];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            logic ov;
            ov = m_busy[i] && (m_cnt[i] == WD[i]);
            chk("in_ready", i, 33'(d_ir[i]), 33'(!m_busy[i]));
            chk("busy", i, 33'(d_bz[i]), 33'(m_busy[i]));
            chk("out_valid", i, 33'(d_ov[i]), 33'(ov));
            if (ov) begin
               chk("sum", i, 33'(d_sum[i]), m_exp[i] & msk(i));
               chk("cout", i, 33'(d_co[i]), 33'(m_exp[i][WD[i]]));
            end else if (!m_busy[i]) begin
               chk("idle_sum", i, 33'(d_sum[i]), m_last[i] & msk(i));
               chk("idle_cout", i, 33'(d_co[i]), 33'(m_last[i][WD[i]]));
            end
         end
      end
   end

   // One operation: accept, check latency and result, optionally stall the
   // consumer for 'hold' cycles (with an ignored in_valid pulse), then consume.
   task automatic op(int i, logic [31:0] a, logic [31:0] b, logic c, int hold,
                     logic [31:0] es, logic ec);
      int n;
      int lat;
      @(posedge clk); #1;
      n = 0;
      while (!d_ir[i] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_wait", i, 33'(d_ir[i]), 33'd1);
      in_valid[i] = 1'b1; a_in[i] = a; b_in[i] = b; cin[i] = c;
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      lat = 0;
      while (!d_ov[i] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", i, 33'(lat), 33'(WD[i]));
      chk("op_sum", i, 33'(d_sum[i]), 33'(es));
      chk("op_cout", i, 33'(d_co[i]), 33'(ec));
      for (int k = 0; k < hold; k++) begin
         if (k == 2) begin
            in_valid[i] = 1'b1; a_in[i] = 32'h11;
         end else begin
            in_valid[i] = 1'b0;
         end
         @(posedge clk); #1;
         chk("hold_valid", i, 33'(d_ov[i]), 33'd1);
         chk("hold_sum", i, 33'(d_sum[i]), 33'(es));
         chk("hold_cout", i, 33'(d_co[i]), 33'(ec));
      end
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
      chk("ready_after_ack", i, 33'(d_ir[i]), 33'd1);
   endtask

   logic [31:0] bb_a[3]  = '{32'h01, 32'h80, 32'h0F};
   logic [31:0] bb_b[3]  = '{32'h02, 32'h80, 32'hF1};
   logic [31:0] bb_s[3]  = '{32'h03, 32'h00, 32'h00};
   logic        bb_c[3]  = '{1'b0, 1'b1, 1'b1};

   initial begin
      int acc[3];
      int n;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; cin[i] = 1'b0;
         a_in[i] = '0; b_in[i] = '0;
      end
      #2;
      for (int i = 0; i < 2; i++) begin
         chk("rst_in_ready", i, 33'(d_ir[i]), 33'd1);
         chk("rst_out_valid", i, 33'(d_ov[i]), 33'd0);
         chk("rst_busy", i, 33'(d_bz[i]), 33'd0);
         chk("rst_sum", i, 33'(d_sum[i]), 33'd0);
         chk("rst_cout", i, 33'(d_co[i]), 33'd0);
      end
      chk_en = 1'b1;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Directed single operations on the 8-bit instance.
      op(0, 32'h5A, 32'h3C, 1'b0, 5, 32'h96, 1'b0);
      chk("model_pin_96", 0, m_last[0], 33'h096);
      op(0, 32'h11, 32'h22, 1'b0, 0, 32'h33, 1'b0);
      op(0, 32'hFF, 32'h01, 1'b0, 0, 32'h00, 1'b1);
      op(0, 32'hFF, 32'hFF, 1'b1, 0, 32'hFF, 1'b1);
      chk("model_pin_1ff", 0, m_last[0], 33'h1FF);

      // Back-to-back with in_valid and out_ready held high.
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      for (int p = 0; p < 3; p++) begin
         n = 0;
         while (!d_ir[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         chk("b2b_ready", 0, 33'(d_ir[0]), 33'd1);
         in_valid[0] = 1'b1; a_in[0] = bb_a[p]; b_in[0] = bb_b[p]; cin[0] = 1'b0;
         acc[p] = cyc;
         if (p > 0) chk("b2b_spacing", 0, 33'(acc[p] - acc[p-1]), 33'd10);
         @(posedge clk); #1;
         n = 0;
         while (!d_ov[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         chk("b2b_sum", 0, 33'(d_sum[0]), 33'(bb_s[p]));
         chk("b2b_cout", 0, 33'(d_co[0]), 33'(bb_c[p]));
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b0;

      // Reset in the middle of RUN.
      @(posedge clk); #1;
      in_valid[0] = 1'b1; a_in[0] = 32'hAA; b_in[0] = 32'h55; cin[0] = 1'b0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_in_ready", 0, 33'(d_ir[0]), 33'd1);
      chk("midrun_rst_out_valid", 0, 33'(d_ov[0]), 33'd0);
      chk("midrun_rst_busy", 0, 33'(d_bz[0]), 33'd0);
      chk("midrun_rst_sum", 0, 33'(d_sum[0]), 33'd0);
      chk("midrun_rst_cout", 0, 33'(d_co[0]), 33'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      op(0, 32'h01, 32'h01, 1'b0, 0, 32'h02, 1'b0);

      // Exhaustive sweep on the 2-bit instance.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 2; c++) begin
               int s;
               s = a + b + c;
               op(1, 32'(a), 32'(b), c[0], 0, 32'(s % 4), (s >= 4));
            end

      // Random traffic on both instances, checked by the model each cycle.
      repeat (2000) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            in_valid[i]  = ($urandom_range(0, 2) != 0);
            out_ready[i] = ($urandom_range(0, 3) != 0);
            a_in[i] = $urandom;
            b_in[i] = $urandom;
            cin[i]  = $urandom_range(0, 1) == 1;
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0;
         out_ready[i] = 1'b1;
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
